// File: rtl/rect_fill_drawer.sv
// Command-driven rectangle rasteriser feeding the framebuffer pixel write port.
// Optional outline mode is compiled in with `define RECT_OUTLINE_EN.
module rect_fill_drawer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COORD_W = 11,
  parameter int COLOR_W = 8
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  // Handshake: a command transfers on the rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on the state register.
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
`ifdef RECT_OUTLINE_EN
  input  logic               cmd_outline,
`endif
  input  logic               abort,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pixel_write,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]   xl_q, xl_d, xr_q, xr_d, yb_q, yb_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic                 pixel_write_q, pixel_write_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
`ifdef RECT_OUTLINE_EN
  logic [COORD_W-1:0]   yt_q, yt_d;
  logic                 outline_q, outline_d;
  logic                 jump_right;
`endif

  logic [COORD_W-1:0]   n_xl, n_xr, n_yt, n_yb;
  logic                 cmd_empty;

  // Normalised and clipped corners of the command currently on the port.
  always_comb begin
    n_xl      = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
    n_xr      = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
    n_yt      = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
    n_yb      = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
    cmd_empty = (n_xl > X_MAX) || (n_yt > Y_MAX);
    if (n_xr > X_MAX) n_xr = X_MAX;
    if (n_yb > Y_MAX) n_yb = Y_MAX;
  end

`ifdef RECT_OUTLINE_EN
  // Interior rows of an outline only touch the two side columns.
  assign jump_right = outline_q && (x_q == xl_q) && (y_q != yt_q) && (y_q != yb_q);
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xl_d    = xl_q;
    xr_d    = xr_q;
    yb_d    = yb_q;
    color_d = color_q;
`ifdef RECT_OUTLINE_EN
    yt_d      = yt_q;
    outline_d = outline_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          color_d = cmd_color;
          if (cmd_empty) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAW;
            x_d     = n_xl;
            y_d     = n_yt;
            xl_d    = n_xl;
            xr_d    = n_xr;
            yb_d    = n_yb;
`ifdef RECT_OUTLINE_EN
            yt_d      = n_yt;
            outline_d = cmd_outline;
`endif
          end
        end
      end
      ST_DRAW: begin
        if (abort || ((x_q == xr_q) && (y_q == yb_q))) begin
          state_d = ST_DONE;
        end else if (x_q < xr_q) begin
`ifdef RECT_OUTLINE_EN
          x_d = jump_right ? xr_q : x_q + COORD_W'(1);
`else
          x_d = x_q + COORD_W'(1);
`endif
        end else begin
          x_d = xl_q;
          y_d = y_q + COORD_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are decoded from the state being entered.
    pixel_write_d = (state_d == ST_DRAW);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      xl_q          <= '0;
      xr_q          <= '0;
      yb_q          <= '0;
      color_q       <= '0;
      pixel_write_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef RECT_OUTLINE_EN
      yt_q          <= '0;
      outline_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      xl_q          <= xl_d;
      xr_q          <= xr_d;
      yb_q          <= yb_d;
      color_q       <= color_d;
      pixel_write_q <= pixel_write_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef RECT_OUTLINE_EN
      yt_q          <= yt_d;
      outline_q     <= outline_d;
`endif
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign x           = x_q;
  assign y           = y_q;
  assign pix_color   = color_q;
  assign pixel_write = pixel_write_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_rect_fill_drawer.sv
// Self-checking bench for rect_fill_drawer: directed cases from the test plan
// plus randomized commands compared against a pixel-list reference model.
module tb_rect_fill_drawer;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 11;
  localparam int COLOR_W = 8;
  localparam int W       = 2 * COORD_W + COLOR_W;

  logic               CLOCK_50;
  logic               reset_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [COLOR_W-1:0] cmd_color;
  logic               cmd_outline;
  logic               abort;
  logic [COORD_W-1:0] x, y;
  logic [COLOR_W-1:0] pix_color;
  logic               pixel_write, busy, done;
  logic [1:0]         state_dbg;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  rect_fill_drawer #(
    .H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W), .COLOR_W(COLOR_W)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_x1     (cmd_x1),
    .cmd_y1     (cmd_y1),
    .cmd_color  (cmd_color),
`ifdef RECT_OUTLINE_EN
    .cmd_outline(cmd_outline),
`endif
    .abort      (abort),
    .x          (x),
    .y          (y),
    .pix_color  (pix_color),
    .pixel_write(pixel_write),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: the list of pixels a command should write, in raster order.
  task automatic build_expected(input int x0, input int y0, input int x1, input int y1,
                                input logic [COLOR_W-1:0] col, input bit outl,
                                input int abort_at);
    int xl, xr, yt, yb;
    exp_q.delete();
    xl = (x0 < x1) ? x0 : x1;
    xr = (x0 < x1) ? x1 : x0;
    yt = (y0 < y1) ? y0 : y1;
    yb = (y0 < y1) ? y1 : y0;
    if (xl > H_RES - 1 || yt > V_RES - 1) return;
    if (xr > H_RES - 1) xr = H_RES - 1;
    if (yb > V_RES - 1) yb = V_RES - 1;
    for (int yy = yt; yy <= yb; yy++)
      for (int xx = xl; xx <= xr; xx++)
        if (!outl || yy == yt || yy == yb || xx == xl || xx == xr)
          exp_q.push_back({COORD_W'(xx), COORD_W'(yy), col});
    if (abort_at > 0)
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
  endtask

  // Driver + scoreboard for one command; entered and left on a falling edge.
  task automatic run_cmd(input string name, input int x0, input int y0, input int x1,
                         input int y1, input logic [COLOR_W-1:0] col, input bit outl,
                         input int abort_at);
    logic [W-1:0] e;
    int k;
    build_expected(x0, y0, x1, y1, col, outl, abort_at);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got cmd_ready=%b want 1", name, cmd_ready);
    end
    cmd_x0 = COORD_W'(x0); cmd_y0 = COORD_W'(y0);
    cmd_x1 = COORD_W'(x1); cmd_y1 = COORD_W'(y1);
    cmd_color = col; cmd_outline = outl; cmd_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    cmd_valid = 1'b0;
    cmd_x0 = COORD_W'($urandom); cmd_y0 = COORD_W'($urandom);
    cmd_x1 = COORD_W'($urandom); cmd_y1 = COORD_W'($urandom);
    cmd_color = COLOR_W'($urandom); cmd_outline = 1'($urandom);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge CLOCK_50);
      abort = 1'b0;
      e = exp_q.pop_front();
      k++;
      checks++;
      if (pixel_write !== 1'b1 || {x, y, pix_color} !== e) begin
        errors++;
        $display("FAIL %s write%0d: got pw=%b x=%0d y=%0d c=%h want pw=1 x=%0d y=%0d c=%h",
                 name, k, pixel_write, x, y, pix_color,
                 e[W-1 -: COORD_W], e[COLOR_W +: COORD_W], e[COLOR_W-1:0]);
      end
      if (k == abort_at) abort = 1'b1;
    end
    @(negedge CLOCK_50);
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || pixel_write !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle: got done=%b pw=%b busy=%b rdy=%b want 1 0 1 0",
               name, done, pixel_write, busy, cmd_ready);
    end
    @(negedge CLOCK_50);
    checks++;
    if (done !== 1'b0 || pixel_write !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after: got done=%b pw=%b busy=%b rdy=%b want 0 0 0 1",
               name, done, pixel_write, busy, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_outline = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_color = '0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if (pixel_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        x !== '0 || y !== '0 || pix_color !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pw=%b busy=%b done=%b x=%0d y=%0d c=%h want all 0",
               pixel_write, busy, done, x, y, pix_color);
    end
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_solid();
    run_cmd("solid_3x2", 10, 5, 12, 6, 8'hA5, 1'b0, 0);
    run_cmd("swapped_3x2", 12, 6, 10, 5, 8'hA5, 1'b0, 0);
    run_cmd("single_px", 100, 200, 100, 200, 8'h3C, 1'b0, 0);
  endtask

  task automatic test_clip();
    run_cmd("clip_corner", 638, 478, 700, 900, 8'h5A, 1'b0, 0);
    run_cmd("clip_empty_x", 640, 0, 650, 5, 8'h11, 1'b0, 0);
    run_cmd("clip_empty_y", 0, 480, 5, 2047, 8'h22, 1'b0, 0);
    run_cmd("clip_max_coords", 2047, 2047, 639, 479, 8'h77, 1'b0, 0);
  endtask

  task automatic test_abort();
    run_cmd("abort_100x1", 0, 0, 99, 0, 8'hC3, 1'b0, 5);
    run_cmd("after_abort", 20, 20, 21, 21, 8'h0F, 1'b0, 0);
  endtask

  task automatic test_reset_mid_draw();
    int k;
    cmd_x0 = 11'd5; cmd_y0 = 11'd7; cmd_x1 = 11'd14; cmd_y1 = 11'd7;
    cmd_color = 8'hEE; cmd_outline = 1'b0; cmd_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 cmd_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 20 && k < 3; i++) begin
      @(negedge CLOCK_50);
      if (pixel_write === 1'b1) k++;
    end
    checks++;
    if (k != 3 || x !== 11'd7) begin
      errors++;
      $display("FAIL mid_draw_reach: got writes=%0d x=%0d want 3 x=7", k, x);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (pixel_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        x !== '0 || y !== '0 || pix_color !== '0) begin
      errors++;
      $display("FAIL mid_draw_reset: got pw=%b busy=%b done=%b x=%0d y=%0d c=%h want all 0",
               pixel_write, busy, done, x, y, pix_color);
    end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (pixel_write !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_release: got pw=%b busy=%b want 0 0", pixel_write, busy);
    end
    run_cmd("post_reset_1x1", 3, 4, 3, 4, 8'h99, 1'b0, 0);
  endtask

`ifdef RECT_OUTLINE_EN
  task automatic test_outline();
    run_cmd("outline_4x3", 0, 0, 3, 2, 8'h81, 1'b1, 0);
    run_cmd("outline_1x5", 50, 50, 50, 54, 8'h82, 1'b1, 0);
    run_cmd("outline_clip", 636, 476, 900, 900, 8'h83, 1'b1, 0);
  endtask
`endif

  task automatic pick_axis(input int res, output int a, output int b);
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) begin
      a = $urandom_range(0, res - 8);
      b = a + $urandom_range(0, 7);
    end else if (r < 9) begin
      a = $urandom_range(res - 6, res - 1);
      b = $urandom_range(res - 6, 2047);
    end else begin
      a = $urandom_range(res, 2047);
      b = $urandom_range(res, 2047);
    end
    if ($urandom_range(0, 1) == 1) begin
      r = a; a = b; b = r;
    end
  endtask

  task automatic test_random();
    int x0, y0, x1, y1, ab;
    bit outl;
    for (int i = 0; i < 40; i++) begin
      pick_axis(H_RES, x0, x1);
      pick_axis(V_RES, y0, y1);
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 0;
`ifdef RECT_OUTLINE_EN
      outl = 1'($urandom_range(0, 1));
`else
      outl = 1'b0;
`endif
      run_cmd($sformatf("rand%0d", i), x0, y0, x1, y1, COLOR_W'($urandom), outl, ab);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_a", 1, 1, 2, 1, 8'h10, 1'b0, 0);
    run_cmd("b2b_b", 639, 479, 639, 479, 8'h20, 1'b0, 0);
    run_cmd("b2b_c", 700, 10, 800, 20, 8'h30, 1'b0, 0);
    run_cmd("b2b_d", 4, 9, 0, 8, 8'h40, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_solid();
    test_clip();
    test_abort();
    test_reset_mid_draw();
`ifdef RECT_OUTLINE_EN
    test_outline();
`endif
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
